// File: rtl/activation_arbiter_if.sv
// Handshake bundle between the neuron accumulators, the shared activation
// stage and the layer output buffer.
interface activation_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) ();
  logic [N_REQ-1:0]    req_valid;
  logic [32*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]    req_ready;
  logic                out_valid;
  logic [31:0]         out_data;
  logic [ID_W-1:0]     out_id;
  logic                out_ready;

  // Environment side: drives requests and downstream ready.
  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_id
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_id
  );
endinterface

// File: rtl/activation_arbiter.sv
// Round-robin arbiter sharing one activation stage (linear / ReLU) between
// N_REQ accumulator sources, with a one-deep registered output.
module activation_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic                aclk,
  input  logic                aresetn,
  activation_arbiter_if.slave bus,
  input  logic [1:0]          act_sel,
  output logic [15:0]         xfer_count
);

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic            out_valid_q, out_valid_d;
  logic [31:0]     out_data_q, out_data_d;
  logic [ID_W-1:0] out_id_q, out_id_d;
  logic [15:0]     xfer_count_q, xfer_count_d;

  logic [ID_W-1:0] gnt;
  logic            any_valid;
  logic            fire;
  logic [31:0]     act_val;

  // Round-robin search starting at ptr, wrapping N_REQ-1 -> 0.
  always_comb begin
    int unsigned idx;
    gnt       = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!any_valid && bus.req_valid[ID_W'(idx)]) begin
        any_valid = 1'b1;
        gnt       = ID_W'(idx);
      end
    end
  end

  // Handshake, activation function and next-state for the output stage.
  always_comb begin
    fire          = (!out_valid_q || bus.out_ready) && any_valid && aresetn;
    bus.req_ready = fire ? (N_REQ'(1) << gnt) : '0;

    act_val = bus.req_data[32*gnt +: 32];
    if (act_sel == 2'd1 && act_val[31]) act_val = '0;

    ptr_d        = ptr_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_id_d     = out_id_q;
    xfer_count_d = xfer_count_q;

    if (fire) begin
      out_valid_d  = 1'b1;
      out_data_d   = act_val;
      out_id_d     = gnt;
      ptr_d        = (gnt == ID_W'(N_REQ - 1)) ? '0 : gnt + 1'b1;
      xfer_count_d = xfer_count_q + 16'd1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ptr_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_id_q     <= '0;
      xfer_count_q <= '0;
    end else begin
      ptr_q        <= ptr_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_id_q     <= out_id_d;
      xfer_count_q <= xfer_count_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_id    = out_id_q;
  assign xfer_count    = xfer_count_q;

endmodule

// File: tb/tb_activation_arbiter.sv
// Self-checking bench for activation_arbiter (N_REQ = 4): vector table,
// directed corner sequences and randomized traffic against a reference model.
module tb_activation_arbiter;

  localparam int unsigned NR = 4;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [1:0]  act_sel;
  logic [15:0] xfer_count;

  activation_arbiter_if #(.N_REQ(NR), .ID_W(2)) bus ();

  activation_arbiter #(.N_REQ(NR), .ID_W(2)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .bus        (bus),
    .act_sel    (act_sel),
    .xfer_count (xfer_count)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Reference model state: current and value to take at the next edge.
  int          m_ptr, n_ptr;
  bit          m_ov, n_ov;
  logic [31:0] m_od, n_od;
  int          m_oid, n_oid;
  logic [15:0] m_cnt, n_cnt;

  task automatic model_reset();
    m_ptr = 0; m_ov = 0; m_od = '0; m_oid = 0; m_cnt = '0;
  endtask

  // Priority order is the requester list rotated to start at the pointer.
  function automatic int rr_pick(input logic [3:0] v, input int start);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (start + k) % 4;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [31:0] act_fn(input logic [31:0] x, input logic [1:0] sel);
    if (sel == 2'd1 && $signed(x) < 0) return 32'd0;
    return x;
  endfunction

  task automatic drive(input logic [3:0] v, input logic [127:0] d,
                       input logic [1:0] sel, input logic ordy);
    bus.req_valid = v;
    bus.req_data  = d;
    act_sel       = sel;
    bus.out_ready = ordy;
  endtask

  task automatic pre_edge(input bit do_chk);
    int         g;
    bit         acc;
    logic [3:0] er;
    #1;
    acc = !m_ov || bus.out_ready;
    g   = rr_pick(bus.req_valid, m_ptr);
    er  = (acc && g >= 0) ? 4'(1 << g) : 4'b0000;
    if (do_chk) chk("req_ready", 32'(bus.req_ready), 32'(er));
    n_ptr = m_ptr; n_ov = m_ov; n_od = m_od; n_oid = m_oid; n_cnt = m_cnt;
    if (acc && g >= 0) begin
      n_od  = act_fn(bus.req_data[32*g +: 32], act_sel);
      n_oid = g;
      n_ov  = 1;
      n_ptr = (g + 1) % 4;
      n_cnt = m_cnt + 16'd1;
    end else if (m_ov && bus.out_ready) begin
      n_ov = 0;
    end
  endtask

  task automatic post_edge(input bit do_chk);
    @(posedge aclk);
    m_ptr = n_ptr; m_ov = n_ov; m_od = n_od; m_oid = n_oid; m_cnt = n_cnt;
    #1;
    if (do_chk) begin
      chk("out_valid",  32'(bus.out_valid), 32'(m_ov));
      chk("out_id",     32'(bus.out_id),    32'(m_oid));
      chk("out_data",   bus.out_data,       m_od);
      chk("xfer_count", 32'(xfer_count),    32'(m_cnt));
    end
  endtask

  task automatic cycle(input bit do_chk);
    pre_edge(do_chk);
    post_edge(do_chk);
  endtask

  typedef struct {
    logic [3:0]   valid;
    logic [127:0] data;
    logic [1:0]   sel;
    logic         ordy;
    logic [3:0]   exp_ready;
    logic         exp_ov;
    logic [1:0]   exp_id;
    logic [31:0]  exp_data;
    logic [15:0]  exp_cnt;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] v, input logic [127:0] d, input logic [1:0] s,
                              input logic o, input logic [3:0] er, input logic eov,
                              input logic [1:0] eid, input logic [31:0] ed, input logic [15:0] ec);
    vec_t r;
    r.valid = v; r.data = d; r.sel = s; r.ordy = o; r.exp_ready = er;
    r.exp_ov = eov; r.exp_id = eid; r.exp_data = ed; r.exp_cnt = ec;
    return r;
  endfunction

  // Sources: 0 -> 0xA0, 1 -> 0xB1, 2 -> 0xFFFFFFF0, 3 -> 0xD3.
  localparam logic [127:0] RRD = {32'h0000_00D3, 32'hFFFF_FFF0, 32'h0000_00B1, 32'h0000_00A0};

  vec_t tbl[$];

  initial begin
    int exp_ids[4];

    // Round robin, all valid, linear.
    tbl.push_back(mk(4'b1111, RRD, 2'd0, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h0000_00A0, 16'd1));
    tbl.push_back(mk(4'b1111, RRD, 2'd0, 1'b1, 4'b0010, 1'b1, 2'd1, 32'h0000_00B1, 16'd2));
    tbl.push_back(mk(4'b1111, RRD, 2'd0, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hFFFF_FFF0, 16'd3));
    tbl.push_back(mk(4'b1111, RRD, 2'd0, 1'b1, 4'b1000, 1'b1, 2'd3, 32'h0000_00D3, 16'd4));
    tbl.push_back(mk(4'b1111, RRD, 2'd0, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h0000_00A0, 16'd5));
    tbl.push_back(mk(4'b1111, RRD, 2'd0, 1'b1, 4'b0010, 1'b1, 2'd1, 32'h0000_00B1, 16'd6));
    // ReLU on requester 0 only.
    tbl.push_back(mk(4'b0001, {96'h0, 32'hFFFF_FFFF}, 2'd1, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h0000_0000, 16'd7));
    tbl.push_back(mk(4'b0001, {96'h0, 32'h8000_0000}, 2'd1, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h0000_0000, 16'd8));
    tbl.push_back(mk(4'b0001, {96'h0, 32'h0000_0000}, 2'd1, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h0000_0000, 16'd9));
    tbl.push_back(mk(4'b0001, {96'h0, 32'h7FFF_FFFF}, 2'd1, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h7FFF_FFFF, 16'd10));
    tbl.push_back(mk(4'b0001, {96'h0, 32'h0000_0005}, 2'd1, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h0000_0005, 16'd11));
    // Stall then release: next grant follows the held id 0.
    tbl.push_back(mk(4'b1111, RRD, 2'd0, 1'b0, 4'b0000, 1'b1, 2'd0, 32'h0000_0005, 16'd11));
    tbl.push_back(mk(4'b1111, RRD, 2'd0, 1'b0, 4'b0000, 1'b1, 2'd0, 32'h0000_0005, 16'd11));
    tbl.push_back(mk(4'b1111, RRD, 2'd0, 1'b1, 4'b0010, 1'b1, 2'd1, 32'h0000_00B1, 16'd12));

    // Reset state, with every requester asking.
    aresetn = 1'b0;
    model_reset();
    drive(4'b1111, RRD, 2'd0, 1'b1);
    #2;
    chk("rst_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_data",  bus.out_data,       32'h0);
    chk("rst_id",    32'(bus.out_id),    32'h0);
    chk("rst_count", 32'(xfer_count),    32'h0);
    #5 aresetn = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].valid, tbl[i].data, tbl[i].sel, tbl[i].ordy);
      pre_edge(1);
      chk($sformatf("tbl%0d_ready", i), 32'(bus.req_ready), 32'(tbl[i].exp_ready));
      post_edge(1);
      chk($sformatf("tbl%0d_valid", i), 32'(bus.out_valid), 32'(tbl[i].exp_ov));
      chk($sformatf("tbl%0d_id", i),    32'(bus.out_id),    32'(tbl[i].exp_id));
      chk($sformatf("tbl%0d_data", i),  bus.out_data,       tbl[i].exp_data);
      chk($sformatf("tbl%0d_count", i), 32'(xfer_count),    32'(tbl[i].exp_cnt));
    end

    // Sparse: requesters 1 and 3 with ptr at 2 alternate 3,1,3,1.
    exp_ids = '{3, 1, 3, 1};
    for (int i = 0; i < 4; i++) begin
      drive(4'b1010, RRD, 2'd0, 1'b1);
      cycle(1);
      chk($sformatf("sparse%0d_id", i), 32'(bus.out_id), 32'(exp_ids[i]));
    end
    for (int i = 0; i < 3; i++) begin
      drive(4'b0100, RRD, 2'd0, 1'b1);
      cycle(1);
      chk($sformatf("single%0d_id", i), 32'(bus.out_id), 32'd2);
    end

    // Backpressure: one transfer from id 3, then five stalled cycles.
    drive(4'b1111, RRD, 2'd0, 1'b1);
    cycle(1);
    chk("bp_first_id", 32'(bus.out_id), 32'd3);
    for (int i = 0; i < 5; i++) begin
      drive(4'b1111, {$urandom, $urandom, $urandom, $urandom}, 2'($urandom_range(0, 3)), 1'b0);
      pre_edge(1);
      chk($sformatf("bp%0d_ready", i), 32'(bus.req_ready), 32'h0);
      post_edge(1);
      chk($sformatf("bp%0d_id", i),    32'(bus.out_id), 32'd3);
      chk($sformatf("bp%0d_data", i),  bus.out_data,    32'h0000_00D3);
      chk($sformatf("bp%0d_count", i), 32'(xfer_count), 32'd20);
    end
    drive(4'b1111, RRD, 2'd0, 1'b1);
    pre_edge(1);
    chk("bp_release_ready", 32'(bus.req_ready), 32'b0001);
    post_edge(1);
    chk("bp_release_id", 32'(bus.out_id), 32'd0);

    // act_sel change while a ReLU-clamped negative result is held.
    drive(4'b0001, {96'h0, 32'hFFFF_FF00}, 2'd1, 1'b1);
    cycle(1);
    chk("sel_relu_data", bus.out_data, 32'h0);
    drive(4'b0001, {96'h0, 32'hFFFF_FF00}, 2'd0, 1'b0);
    cycle(1);
    chk("sel_held_data", bus.out_data, 32'h0);
    drive(4'b0001, {96'h0, 32'hFFFF_FF00}, 2'd0, 1'b1);
    cycle(1);
    chk("sel_linear_data", bus.out_data, 32'hFFFF_FF00);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [127:0] d;
      for (int j = 0; j < 4; j++) d[32*j +: 32] = $urandom;
      drive(4'($urandom_range(0, 15)), d, 2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
      cycle(1);
    end

    // Reset mid-stream with a result pending.
    drive(4'b1111, RRD, 2'd0, 1'b1);
    cycle(1);
    drive(4'b1111, RRD, 2'd0, 1'b0);
    cycle(1);
    chk("pre_rst_valid", 32'(bus.out_valid), 32'h1);
    aresetn = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'h0);
    chk("mid_rst_data",  bus.out_data,       32'h0);
    chk("mid_rst_id",    32'(bus.out_id),    32'h0);
    chk("mid_rst_count", 32'(xfer_count),    32'h0);
    bus.out_ready = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(bus.req_ready), 32'h0);
    @(posedge aclk);
    #2;
    chk("mid_rst_ready_edge", 32'(bus.req_ready), 32'h0);
    aresetn = 1'b1;
    drive(4'b1111, RRD, 2'd0, 1'b1);
    cycle(1);
    chk("post_rst_id", 32'(bus.out_id), 32'd0);

    // Counter wrap: 65535 transfers total, then one more.
    for (int i = 0; i < 65534; i++) cycle(0);
    chk("count_ffff", 32'(xfer_count), 32'h0000_FFFF);
    cycle(1);
    chk("count_wrap", 32'(xfer_count), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/activation_arbiter.md
# activation_arbiter

Round-robin arbiter and sequencer that shares one activation-function stage between `N_REQ` neuron result sources. It accepts 32-bit signed accumulator results over valid/ready handshakes, applies the selected activation (linear pass-through or ReLU), and presents the registered result with its source index on a single valid/ready output. It sits between the parallel neuron accumulators of a layer and the layer's output buffer.

## Interface
- `N_REQ`, default 4, number of requesters (2..16).
- `ID_W`, default `$clog2(N_REQ)`, width of the source index.
- `aclk`  in  1  single clock; all logic on rising edge.
- `aresetn`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  bit i: requester i has a result.
- `req_data`  in  32*N_REQ  slice [32*i +: 32] is requester i's signed result.
- `req_ready`  out  N_REQ  bit i: requester i's transfer is accepted this cycle.
- `act_sel`  in  2  activation select: 0 linear, 1 ReLU, 2/3 linear (reserved).
- `out_valid`  out  1  output register holds a result.
- `out_data`  out  32  activated result.
- `out_id`  out  ID_W  index of the requester that produced `out_data`.
- `out_ready`  in  1  downstream accepts the output.
- `xfer_count`  out  16  number of accepted input transfers, modulo 2^16.

## Operation
- Accept condition: `accept = !out_valid || out_ready`. The output register is a one-deep pipeline stage that refills in the same cycle it drains.
- Grant: combinational round-robin search over `req_valid`, starting at index `ptr` and wrapping from N_REQ-1 to 0. The first set bit wins (`gnt`).
- `req_ready[gnt]` = 1 only when `accept` and at least one `req_valid` bit is set. All other `req_ready` bits are 0. `req_ready` never asserts for a requester whose `req_valid` is low.
- On an accepted transfer:
  - `out_data` ← f(`req_data[gnt]`) using `act_sel` as sampled in that cycle.
  - `out_id` ← `gnt`.
  - `out_valid` ← 1.
  - `ptr` ← (`gnt`+1) mod N_REQ.
  - `xfer_count` increments, wrapping from 0xFFFF to 0.
- With no accepted transfer: if `out_valid && out_ready`, then `out_valid` ← 0. Otherwise the output holds.
- `ptr` changes only on an accepted transfer. A requester that is skipped because its `req_valid` is low loses no priority.
- Linear: f(x) = x.
- ReLU: f(x) = x[31] ? 0 : x. The input is two's complement; 0x80000000 maps to 0 and 0x7FFFFFFF passes unchanged.
- Output stability: while `out_valid && !out_ready`, `out_data` and `out_id` are held constant and all `req_ready` bits are 0.
- `act_sel` changes affect only transfers accepted afterwards, never a result already in the output register.
- Requesters may deassert `req_valid` without handshaking. The arbiter does not latch requests.

## Timing
- Reset values (asynchronous, while `aresetn`=0): `out_valid`=0, `out_data`=0, `out_id`=0, `xfer_count`=0, `ptr`=0.
- While in reset, `req_ready` is all 0.
- Reset asserted mid-operation discards any pending output with no partial handshake.
- After `aresetn` rises, the first accepted transfer can occur on the first clock edge.
- Latency: 1 cycle. A result accepted at edge k appears on `out_data` with `out_valid`=1 after edge k.
- Throughput: one result per cycle while `out_ready`=1 and any `req_valid` is set.
- `req_ready` depends combinationally on `req_valid`, `out_valid`, `out_ready`, and `ptr`. There is no combinational path from `req_data` or `act_sel` to any output.
- Simultaneous drain and fill in the same cycle: `out_valid` stays 1 and `out_data`/`out_id` take the new result.
- Single requester continuously valid: it is granted every accept cycle; `ptr` cycles back to it each time.

## Test plan
- Reset check: assert `aresetn`=0 mid-stream with `out_valid`=1 -> `out_valid`=0, `out_data`=0, `out_id`=0, `xfer_count`=0, `req_ready`=0. After release with all 4 requesters valid, the first grant is id 0.
- Round-robin: N_REQ=4, all `req_valid`=1, `out_ready`=1, linear -> `out_id` sequence 0,1,2,3,0,1. After 6 transfers `xfer_count`=6 and `out_data` equals each source's `req_data`.
- ReLU: `act_sel`=1 with inputs 0xFFFFFFFF, 0x80000000, 0x00000000, 0x7FFFFFFF, 0x00000005 -> outputs 0, 0, 0, 0x7FFFFFFF, 5.
- Backpressure: hold `out_ready`=0 for 5 cycles after one transfer -> `out_data`/`out_id` stable, all `req_ready`=0, `xfer_count` unchanged. On raising `out_ready`, the next grant is the next valid index after the held id, in the same cycle.
- Sparse requests: only requesters 1 and 3 valid, `ptr`=2 -> grants alternate 3,1,3,1. With only requester 2 valid -> it is granted every cycle.
- Counter wrap and select change: preload 65535 transfers, then one more -> `xfer_count`=0. Switching `act_sel` from 1 to 0 while a negative result is held in the output register -> the held value stays 0, and the next transfer passes the negative value unchanged.
